muldiv_unit: RTL
================

// Module: muldiv_unit
// PURPOSE
// - Iterative RV32M/RV64M multiply/divide execute unit; successor to the single-cycle ALU op decoder.
// - Decodes the M-extension op from the raw instruction word (funct7=0000001, funct3 selects op) and computes the result over multiple cycles.
// - Sits beside the base ALU in EX; the pipeline stalls on in_ready/out_valid handshakes.
// PARAMETERS
// - XLEN         32  operand/result width; legal values 8, 16, 32, 64.
// - FAST_SPECIAL 1   1: divide-by-zero and signed overflow complete in 1 cycle; 0: they take the full iterative path.
// PORTS
// - clk        in   1      rising-edge clock
// - rst        in   1      asynchronous, active-high reset
// - in_valid   in   1      request valid
// - in_ready   out  1      unit can accept (high only in IDLE)
// - instr      in   32     instruction word; funct7=[31:25], funct3=[14:12], opcode=[6:0]
// - rs1        in   XLEN   operand A
// - rs2        in   XLEN   operand B
// - flush      in   1      abort in-flight op; no result produced
// - out_valid  out  1      result valid; held until out_ready
// - out_ready  in   1      consumer accepts result
// - result     out  XLEN   product/quotient/remainder
// - illegal    out  1      with out_valid: instr was not an M-op, result = 0
// BEHAVIOUR
// - Reset (async): state=IDLE, in_ready=1, out_valid=0, result=0, illegal=0, count=0.
// - Accept: in_valid & in_ready at a rising edge; operands, op and signs are latched; in_ready drops next cycle.
// - Op map, funct3: 000 MUL (low XLEN), 001 MULH (s*s), 010 MULHSU (s*u), 011 MULHU (u*u), 100 DIV, 101 DIVU, 110 REM, 111 REMU.
// - M-op legal iff opcode=0110011 and funct7=0000001; otherwise IDLE->DONE with illegal=1, result=0.
// - FSM: IDLE -> CALC -> FIX -> DONE -> IDLE.
//   - IDLE: wait for accept. Compute abs values of signed operands; record result-sign flags.
//   - CALC: one radix-2 step per cycle; count 0..XLEN-1. Mul: shift-add into a 2*XLEN accumulator. Div: restoring shift-subtract.
//   - FIX: apply sign correction. Quotient sign = s1^s2. Remainder sign = s1. Product sign = sign of signed operands.
//     Then select low/high half or quotient/remainder into result.
//   - DONE: out_valid=1; on out_ready go to IDLE; in_ready=1 on the next cycle. No accept in the same cycle as DONE->IDLE.
// - Latency, accept edge to out_valid: XLEN+2 edges (XLEN CALC edges + FIX edge + DONE entry). XLEN=32 gives 34.
// - Special cases, per RISC-V spec:
//   - Divide by 0: DIV/DIVU quotient = all ones; REM/REMU = rs1.
//   - Signed overflow (rs1 = most-negative, rs2 = -1): DIV = rs1; REM = 0.
//   - FAST_SPECIAL=1: these and illegal ops go IDLE->DONE, out_valid after 1 edge.
//   - FAST_SPECIAL=0: illegal is still 1-edge; arithmetic special cases take the iterative path and the FIX stage forces the spec values.
// - Width rules: all internal arithmetic unsigned XLEN+1 bits; MULHSU treats rs2 as unsigned, so the product sign is s1 only.
// - flush: in CALC/FIX/DONE, forces IDLE at the next edge, out_valid=0, result unchanged. In IDLE, flush has priority over in_valid (no accept).
// - Back-pressure: result and illegal stable while out_valid & !out_ready.
// - rst asserted mid-op: immediate IDLE; no partial result ever presented.
// STRUCTURE
// - Package muldiv_pkg holds:
//   - typedef enum {IDLE, CALC, FIX, DONE} state_t
//   - typedef enum for the 8 funct3 ops
//   - localparams OPC_OP=7'b0110011 and F7_MULDIV=7'b0000001
// - One sub-module, muldiv_decode: combinational instr -> {op, legal, signed_a, signed_b}.
// - Datapath (shared accumulator/shift register) and FSM live in muldiv_unit.
// TESTING (XLEN=32 unless noted)
// - MUL rs1=7, rs2=-3 -> result=0xFFFFFFEB after 34 edges; MULH same operands -> 0xFFFFFFFF.
// - MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU rs1=-1, rs2=0xFFFFFFFF -> 0xFFFFFFFF.
// - DIV -7/2 -> -3, REM -> -1. DIVU 0x80000000/0 -> 0xFFFFFFFF in 1 edge (FAST_SPECIAL=1); REMU -> 0x80000000.
// - DIV 0x80000000/-1 -> 0x80000000, REM -> 0; repeat with FAST_SPECIAL=0 -> same values at 34 edges.
// - instr funct7=0100000 -> illegal=1, result=0 after 1 edge. Hold out_ready=0 for 5 cycles -> outputs stable, in_ready=0.
// - Assert flush, and separately rst, at CALC count=10 -> IDLE next edge, no out_valid. Next op (XLEN=8 build: DIVU 200/7) -> 28.

Source files
------------

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared types and encodings for the M-extension multiply/divide unit
package muldiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_t;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

endpackage

// File: rtl/muldiv_decode.sv
// rtl/muldiv_decode.sv - combinational M-op decode from the raw instruction word
module muldiv_decode
    import muldiv_pkg::*;
(
    input  logic [31:0] instr,
    output op_t         op,
    output logic        legal,
    output logic        signed_a,
    output logic        signed_b
);

    // register and rd fields play no part in selecting the operation
    logic unused_fields;
    assign unused_fields = ^{instr[24:15], instr[11:7]};

    // funct3 picks the op; operand signedness follows from the op
    always_comb begin
        op       = op_t'(instr[14:12]);
        legal    = (instr[6:0] == OPC_OP) && (instr[31:25] == F7_MULDIV);
        signed_a = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
        signed_b = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative radix-2 RV32M/RV64M multiply/divide execute unit
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN         = 32,
    parameter bit          FAST_SPECIAL = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            illegal
);

    localparam int unsigned CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    op_t  dec_op;
    logic dec_legal;
    logic dec_signed_a;
    logic dec_signed_b;

    muldiv_decode u_decode (
        .instr    (instr),
        .op       (dec_op),
        .legal    (dec_legal),
        .signed_a (dec_signed_a),
        .signed_b (dec_signed_b)
    );

    state_t              state_q, state_d;
    op_t                 op_q, op_d;
    logic [CW-1:0]       count_q, count_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     opnd_q, opnd_d;
    logic [XLEN-1:0]     rs1_q, rs1_d;
    logic                neg_a_q, neg_a_d;
    logic                neg_b_q, neg_b_d;
    logic                dz_q, dz_d;
    logic                ovf_q, ovf_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic                illegal_q, illegal_d;

    // Architectural results for divide-by-zero and signed overflow
    function automatic logic [XLEN-1:0] special_res(input op_t op, input logic [XLEN-1:0] a,
                                                    input logic dz);
        if (dz)
            return ((op == OP_DIV) || (op == OP_DIVU)) ? {XLEN{1'b1}} : a;
        else
            return (op == OP_DIV) ? a : {XLEN{1'b0}};
    endfunction

    // Operand preparation at accept time: magnitudes plus sign flags
    logic            in_neg_a, in_neg_b, in_is_div, in_dz, in_ovf;
    logic [XLEN-1:0] abs_a, abs_b;
    assign in_neg_a  = dec_signed_a & rs1[XLEN-1];
    assign in_neg_b  = dec_signed_b & rs2[XLEN-1];
    assign abs_a     = in_neg_a ? -rs1 : rs1;
    assign abs_b     = in_neg_b ? -rs2 : rs2;
    assign in_is_div = dec_op[2];
    assign in_dz     = in_is_div & (rs2 == '0);
    assign in_ovf    = in_is_div & dec_signed_b & (rs1 == MOST_NEG) & (rs2 == {XLEN{1'b1}});

    // Shift-add step: low half holds the remaining multiplier bits
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

    // Restoring divide step: upper half is the partial remainder, low half shifts in quotient bits
    logic [XLEN:0]     div_rem, div_diff;
    logic              div_ge;
    logic [2*XLEN-1:0] div_next;
    assign div_rem  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    assign div_diff = div_rem - {1'b0, opnd_q};
    assign div_ge   = div_rem >= {1'b0, opnd_q};
    assign div_next = {(div_ge ? div_diff[XLEN-1:0] : div_rem[XLEN-1:0]), acc_q[XLEN-2:0], div_ge};

    // Sign correction and final selection
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix, rem_fix, fix_res;
    assign prod_fix = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
    assign quot_fix = (neg_a_q ^ neg_b_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    assign rem_fix  = neg_a_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

    // Pick the half or quotient/remainder the op asks for, overriding special cases
    always_comb begin
        fix_res = '0;
        case (op_q)
            OP_MUL:                         fix_res = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:   fix_res = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:                fix_res = quot_fix;
            default:                        fix_res = rem_fix;
        endcase
        if (dz_q || ovf_q)
            fix_res = special_res(op_q, rs1_q, dz_q);
    end

    // Next-state and datapath control
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        count_d   = count_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        rs1_d     = rs1_q;
        neg_a_d   = neg_a_q;
        neg_b_d   = neg_b_q;
        dz_d      = dz_q;
        ovf_d     = ovf_q;
        result_d  = result_q;
        illegal_d = illegal_q;
        case (state_q)
            IDLE: begin
                if (!flush && in_valid) begin
                    op_d      = dec_op;
                    illegal_d = !dec_legal;
                    rs1_d     = rs1;
                    neg_a_d   = in_neg_a;
                    neg_b_d   = in_neg_b;
                    dz_d      = in_dz;
                    ovf_d     = in_ovf;
                    count_d   = '0;
                    if (!dec_legal) begin
                        result_d = '0;
                        state_d  = DONE;
                    end else if (FAST_SPECIAL && (in_dz || in_ovf)) begin
                        result_d = special_res(dec_op, rs1, in_dz);
                        state_d  = DONE;
                    end else begin
                        acc_d   = in_is_div ? {{XLEN{1'b0}}, abs_a} : {{XLEN{1'b0}}, abs_b};
                        opnd_d  = in_is_div ? abs_b : abs_a;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    acc_d   = op_q[2] ? div_next : mul_next;
                    count_d = count_q + 1'b1;
                    if (count_q == CW'(XLEN - 1))
                        state_d = FIX;
                end
            end
            FIX: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    result_d = fix_res;
                    state_d  = DONE;
                end
            end
            default: begin
                if (flush || out_ready)
                    state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            op_q      <= OP_MUL;
            count_q   <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            rs1_q     <= '0;
            neg_a_q   <= 1'b0;
            neg_b_q   <= 1'b0;
            dz_q      <= 1'b0;
            ovf_q     <= 1'b0;
            result_q  <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            count_q   <= count_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            rs1_q     <= rs1_d;
            neg_a_q   <= neg_a_d;
            neg_b_q   <= neg_b_d;
            dz_q      <= dz_d;
            ovf_q     <= ovf_d;
            result_q  <= result_d;
            illegal_q <= illegal_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign illegal   = illegal_q;

endmodule
